// File: rtl/seq_mult8.sv
// Unsigned 8x8 shift-and-add multiplier: one adder pass per cycle, 8 iterations,
// 16-bit registered product with a start/busy/done handshake.

module adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] sum,
    output logic       Cout
);
    always_comb begin
        {Cout, sum} = {1'b0, A} + {1'b0, B};
    end
endmodule

module seq_mult8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [7:0]  m;
    logic [7:0]  acc;
    logic [7:0]  q;
    logic [2:0]  cnt;
    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        cout;
    logic [15:0] shifted;

    always_comb begin
        addend  = q[0] ? m : '0;
        // Carry lands in acc[7] after the shift, so the 17th bit C is always
        // zero post-shift and is not kept as a separate register.
        shifted = {cout, sum, q[7:1]};
    end

    adder u_adder (
        .A    (acc),
        .B    (addend),
        .sum  (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    {acc, q} <= shifted;
                    cnt      <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= shifted;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult8.sv
// Directed bench for seq_mult8: hand-computed products, handshake timing,
// start-while-busy, reset abort and back-to-back operation.

module tb_seq_mult8;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_checks;
    int n_pass;

    seq_mult8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Edge 0 always carries start with a0/b0; later edges use a1/b1 and the masks.
    // Outputs are sampled 1 time unit after each edge.
    task automatic run_window(input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1,
                              input logic [31:0] smask, input logic [31:0] rmask,
                              input int n,
                              output int dcnt, output int dfirst, output int dlast,
                              output int bcnt);
        dcnt = 0; dfirst = -1; dlast = -1; bcnt = 0;
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            start = (j == 0) || smask[j];
            a     = (j == 0) ? a0 : a1;
            b     = (j == 0) ? b0 : b1;
            rst   = rmask[j];
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dfirst < 0) dfirst = j;
                dlast = j;
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic mult_case(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input logic [15:0] exp);
        int dc, df, dl, bc;
        run_window(x, y, 8'hAA, 8'h55, 32'h0, 32'h0, 11, dc, df, dl, bc);
        check({tag, "_product"}, product, exp);
        check({tag, "_done_edge"}, df, 8);
        check({tag, "_done_count"}, dc, 1);
        check({tag, "_busy_cycles"}, bc, 9);
    endtask

    initial begin
        int dc, df, dl, bc;
        n_checks = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_product", product, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        mult_case("basic_13x11", 8'd13, 8'd11, 16'h008F);
        mult_case("max_255x255", 8'd255, 8'd255, 16'hFE01);
        mult_case("zero_0x200", 8'd0, 8'd200, 16'h0000);
        mult_case("ident_1x200", 8'd1, 8'd200, 16'h00C8);
        mult_case("pow_128x2", 8'd128, 8'd2, 16'h0100);
        mult_case("mix_200x3", 8'd200, 8'd3, 16'h0258);

        // Extra start pulses at edge 3 (RUN) and edge 9 (DONE) must be ignored.
        run_window(8'd7, 8'd9, 8'd3, 8'd3, 32'h0000_0208, 32'h0, 12, dc, df, dl, bc);
        check("busy_start_done_count", dc, 1);
        check("busy_start_done_edge", df, 8);
        check("busy_start_product", product, 16'd63);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_hold_product", product, 16'd63);
        check("busy_start_idle_busy", busy, 1'b0);

        // Reset at edge 4 aborts; start is also held there to show rst wins.
        run_window(8'd100, 8'd100, 8'd100, 8'd100, 32'h0000_0010, 32'h0000_0010, 12,
                   dc, df, dl, bc);
        check("abort_done_count", dc, 0);
        check("abort_busy_cycles", bc, 4);
        check("abort_product", product, 16'h0000);
        check("abort_busy", busy, 1'b0);
        mult_case("after_abort_100x100", 8'd100, 8'd100, 16'h2710);

        // Start held high: accepted at edges 0, 10, 20 -> done after 8, 18, 28.
        run_window(8'd6, 8'd7, 8'd6, 8'd7, 32'hFFFF_FFFF, 32'h0, 29, dc, df, dl, bc);
        check("b2b_done_count", dc, 3);
        check("b2b_first_done", df, 8);
        check("b2b_last_done", dl, 28);
        check("b2b_product", product, 16'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
